dma_arbiter_rr: RTL and testbench

Parametrised stream arbiter for the DMA AHB master. It selects one of numb_ch streams per burst, using programmable priority levels with round-robin among equal priorities. An anti-starvation age promotion lets low-priority streams still win. The grant is held for one complete burst, released by an explicit done pulse from the master.

---
 rtl/dma_arbiter_rr.sv | 157 +++++++++++++++
 tb/tb_dma_arbiter_rr.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter_rr.sv
// Burst-level stream arbiter for the DMA AHB master: priority levels with round-robin
// tie-break, age promotion against starvation, and the grant held until the master's done pulse.
module dma_arbiter_rr #(
  parameter int numb_ch   = 8,
  parameter int pl_width  = 2,
  parameter int fifo_size = 5,
  parameter int age_max   = 7,
  localparam int sel_w    = (numb_ch > 1) ? $clog2(numb_ch) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_nreset,
  input  logic [numb_ch-1:0]              i_en_stream,
  input  logic [numb_ch*pl_width-1:0]     i_pl,
  input  logic [2*numb_ch-1:0]            i_size,
  input  logic [2*numb_ch-1:0]            i_burst,
  input  logic [18*numb_ch-1:0]           i_ndt,
  input  logic [(fifo_size+1)*numb_ch-1:0] i_left_bytes,
  input  logic [numb_ch-1:0]              i_requests,
  input  logic [numb_ch-1:0]              i_relevance_req,
  input  logic                            i_master_ready,
  input  logic                            i_xfer_done,
  output logic [sel_w-1:0]                o_stream_sel,
  output logic                            o_master_en,
  output logic                            o_urgent,
  output logic [1:0]                      o_state
);

  localparam int lb_w  = fifo_size + 1;
  localparam int eff_w = pl_width + 1;
  localparam int age_w = 4;

  // Handshake: a grant is offered only while i_master_ready is high in SWAP; once
  // o_master_en is high the grant is owned by the master until its one-cycle i_xfer_done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SWAP = 2'd1,
    ST_WORK = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [sel_w-1:0]         r_sel;
  logic [sel_w-1:0]         r_rr;
  logic                     r_urgent;
  logic [numb_ch-1:0]       w_elig;
  logic [numb_ch*eff_w-1:0] w_eff;
  logic [sel_w-1:0]         w_win;
  logic                     w_win_urg;
  logic                     w_any_elig;
  logic                     w_decide;
  int                       w_key;
  int                       w_dist;
  int                       w_best_key;

  for (genvar g = 0; g < numb_ch; g++) begin : g_ch
    logic [1:0]       w_size;
    logic [1:0]       w_burst;
    logic [2:0]       w_sshift;
    logic [2:0]       w_bshift;
    logic [6:0]       w_need;
    logic [19:0]      w_ndt_bytes;
    logic [lb_w-1:0]  w_left;
    logic             w_room;
    logic             w_urg;
    logic [age_w-1:0] r_age;

    assign w_size      = i_size[2*g +: 2];
    assign w_burst     = i_burst[2*g +: 2];
    assign w_sshift    = w_size[1] ? 3'd2 : (w_size[0] ? 3'd1 : 3'd0);
    // Beats 1/4/8/16 are 2^0/2^2/2^3/2^4, so the burst size is a single shift.
    assign w_bshift    = (w_burst == 2'd0) ? 3'd0 : ({1'b0, w_burst} + 3'd1);
    assign w_need      = 7'd1 << (w_sshift + w_bshift);
    assign w_ndt_bytes = {2'b00, i_ndt[18*g +: 18]} << w_sshift;
    assign w_left      = i_left_bytes[lb_w*g +: lb_w];
    assign w_room      = (32'(w_left) >= 32'(w_need)) ||
                         ((w_left != '0) && (32'(w_ndt_bytes) <= 32'(w_left)));
    assign w_elig[g]   = i_en_stream[g] && (i_requests[g] || !i_relevance_req[g]) && w_room;
    assign w_urg       = (r_age == age_w'(age_max));
    assign w_eff[g*eff_w +: eff_w] = {w_urg, i_pl[g*pl_width +: pl_width]};

    always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
        r_age <= '0;
      end else if (!i_en_stream[g]) begin
        r_age <= '0;
      end else if (w_decide) begin
        if (w_win == sel_w'(g)) begin
          r_age <= '0;
        end else if (w_elig[g] && (r_age != age_w'(age_max))) begin
          r_age <= r_age + age_w'(1);
        end
      end
    end
  end

  assign w_any_elig = |w_elig;

  // Key = effective priority above the inverted search distance from the rr pointer,
  // so the largest key is the highest priority and, among equals, the next in rr order.
  always_comb begin
    w_best_key = -1;
    w_win      = '0;
    w_win_urg  = 1'b0;
    w_key      = 0;
    w_dist     = 0;
    for (int ch = 0; ch < numb_ch; ch++) begin
      if (ch > int'(r_rr)) w_dist = ch - int'(r_rr) - 1;
      else                 w_dist = ch + numb_ch - int'(r_rr) - 1;
      w_key = int'(w_eff[ch*eff_w +: eff_w]) * 32 + (31 - w_dist);
      if (w_elig[ch] && (w_key > w_best_key)) begin
        w_best_key = w_key;
        w_win      = sel_w'(ch);
        w_win_urg  = w_eff[ch*eff_w + eff_w - 1];
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_decide = 1'b0;
    case (r_state)
      ST_IDLE: if (|i_en_stream) w_next = ST_SWAP;
      ST_SWAP: begin
        if (!(|i_en_stream)) begin
          w_next = ST_IDLE;
        end else if (w_any_elig && i_master_ready) begin
          w_next   = ST_WORK;
          w_decide = 1'b1;
        end
      end
      ST_WORK: if (i_xfer_done) w_next = ST_SWAP;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_rr     <= sel_w'(numb_ch - 1);
      r_urgent <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_decide) begin
        r_sel    <= w_win;
        r_rr     <= w_win;
        r_urgent <= w_win_urg;
      end
    end
  end

  assign o_stream_sel = r_sel;
  assign o_master_en  = (r_state == ST_WORK);
  assign o_urgent     = r_urgent;
  assign o_state      = r_state;

endmodule

// File: tb/tb_dma_arbiter_rr.sv
// Bench for dma_arbiter_rr: directed scenarios plus randomized bursts, with expected grants
// from a priority/age/round-robin reference model checked by a grant monitor.
module tb_dma_arbiter_rr;

  localparam int N       = 8;
  localparam int PLW     = 2;
  localparam int FS      = 5;
  localparam int AGE_MAX = 3;
  localparam int SW      = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          en_v = '0;
  logic [N*PLW-1:0]      pl_v = '0;
  logic [2*N-1:0]        size_v = '0;
  logic [2*N-1:0]        burst_v = '0;
  logic [18*N-1:0]       ndt_v = '0;
  logic [(FS+1)*N-1:0]   left_v = '0;
  logic [N-1:0]          req_v = '0;
  logic [N-1:0]          rel_v = '0;
  logic                  ready = 1'b1;
  logic                  done = 1'b0;
  logic [SW-1:0]         o_stream_sel;
  logic                  o_master_en;
  logic                  o_urgent;
  logic [1:0]            o_state;

  dma_arbiter_rr #(.numb_ch(N), .pl_width(PLW), .fifo_size(FS), .age_max(AGE_MAX)) dut (
    .i_clk(clk), .i_nreset(rst_n), .i_en_stream(en_v), .i_pl(pl_v), .i_size(size_v),
    .i_burst(burst_v), .i_ndt(ndt_v), .i_left_bytes(left_v), .i_requests(req_v),
    .i_relevance_req(rel_v), .i_master_ready(ready), .i_xfer_done(done),
    .o_stream_sel(o_stream_sel), .o_master_en(o_master_en), .o_urgent(o_urgent),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [SW:0] exp_q[$];
  logic [SW:0] mon_e;
  logic        prev_en = 1'b0;

  int c_en[N], c_pl[N], c_size[N], c_burst[N], c_ndt[N], c_left[N], c_req[N], c_rel[N];
  int m_age[N];
  int m_rr;
  int cur_sel;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Grant monitor: every rising o_master_en must match the oldest predicted grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (o_master_en && !prev_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant actual sel=%0d expected no grant", o_stream_sel);
        end else begin
          mon_e = exp_q.pop_front();
          check("grant_sel", int'(o_stream_sel), int'(mon_e[SW-1:0]));
          check("grant_urgent", int'(o_urgent), int'(mon_e[SW]));
        end
      end
      prev_en = o_master_en;
    end
  end

  task automatic clear_cfg();
    for (int ch = 0; ch < N; ch++) begin
      c_en[ch] = 0; c_pl[ch] = 0; c_size[ch] = 0; c_burst[ch] = 0;
      c_ndt[ch] = 0; c_left[ch] = 0; c_req[ch] = 0; c_rel[ch] = 0;
    end
  endtask

  task automatic set_stream(input int ch, input int pl);
    c_en[ch] = 1; c_pl[ch] = pl; c_size[ch] = 2; c_burst[ch] = 0;
    c_left[ch] = 32; c_ndt[ch] = 1000; c_req[ch] = 1; c_rel[ch] = 1;
  endtask

  task automatic drive_cfg();
    for (int ch = 0; ch < N; ch++) begin
      en_v[ch]                  = c_en[ch][0];
      pl_v[ch*PLW +: PLW]       = c_pl[ch][PLW-1:0];
      size_v[ch*2 +: 2]         = c_size[ch][1:0];
      burst_v[ch*2 +: 2]        = c_burst[ch][1:0];
      ndt_v[ch*18 +: 18]        = c_ndt[ch][17:0];
      left_v[ch*(FS+1) +: FS+1] = c_left[ch][FS:0];
      req_v[ch]                 = c_req[ch][0];
      rel_v[ch]                 = c_rel[ch][0];
    end
  endtask

  function automatic bit m_elig(input int ch);
    int bytes, beats;
    bytes = (c_size[ch] == 0) ? 1 : (c_size[ch] == 1) ? 2 : 4;
    case (c_burst[ch])
      0:       beats = 1;
      1:       beats = 4;
      2:       beats = 8;
      default: beats = 16;
    endcase
    return (c_en[ch] != 0) && (c_req[ch] != 0 || c_rel[ch] == 0) &&
           (c_left[ch] >= beats * bytes || (c_left[ch] != 0 && c_ndt[ch] * bytes <= c_left[ch]));
  endfunction

  function automatic bit any_elig();
    for (int ch = 0; ch < N; ch++) if (m_elig(ch)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference decision: best effective priority first, then first in rr order holding it.
  task automatic push_expected();
    int  best, win, c, eff[N];
    bit  el[N];
    bit  urg;
    for (int ch = 0; ch < N; ch++) if (c_en[ch] == 0) m_age[ch] = 0;
    best = -1;
    for (int ch = 0; ch < N; ch++) begin
      el[ch]  = m_elig(ch);
      eff[ch] = ((m_age[ch] == AGE_MAX) ? (1 << PLW) : 0) + c_pl[ch];
      if (el[ch] && eff[ch] > best) best = eff[ch];
    end
    win = -1;
    for (int k = 1; k <= N; k++) begin
      c = (m_rr + k) % N;
      if (win < 0 && el[c] && eff[c] == best) win = c;
    end
    if (win < 0) win = 0;
    urg = (m_age[win] == AGE_MAX);
    for (int ch = 0; ch < N; ch++)
      if (el[ch] && ch != win && m_age[ch] < AGE_MAX) m_age[ch]++;
    m_age[win] = 0;
    m_rr       = win;
    cur_sel    = win;
    exp_q.push_back({urg, win[SW-1:0]});
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    @(negedge clk);
    while (o_master_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_timeout", int'(o_master_en === 1'b1), 1);
  endtask

  task automatic start_scenario();
    @(posedge clk); #1;
    drive_cfg();
    push_expected();
    wait_grant();
  endtask

  task automatic finish_burst(input int hold);
    @(posedge clk); #1;
    done = 1'b1;
    if (hold > 0) ready = 1'b0;
    @(posedge clk); #1;
    done = 1'b0;
    @(negedge clk);
    check("gap_en", int'(o_master_en), 0);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    ready = 1'b1;
    if (hold > 0) begin
      @(negedge clk);
      check("hold_en", int'(o_master_en), 0);
    end
    @(negedge clk);
    check("regrant_lat", int'(o_master_en), 1);
  endtask

  // Caller has already driven the next configuration while the current grant is held.
  task automatic next_burst(input int hold);
    @(negedge clk);
    check("lock_en", int'(o_master_en), 1);
    check("lock_sel", int'(o_stream_sel), cur_sel);
    push_expected();
    finish_burst(hold);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_en", int'(o_master_en), 0);
    check("rst_sel", int'(o_stream_sel), 0);
    check("rst_urgent", int'(o_urgent), 0);
    check("rst_state", int'(o_state), 0);
    check("rst_queue_empty", exp_q.size(), 0);
    clear_cfg();
    drive_cfg();
    for (int ch = 0; ch < N; ch++) m_age[ch] = 0;
    m_rr = N - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    @(negedge clk);
    check("idle_done_state", int'(o_state), 0);
    check("idle_done_en", int'(o_master_en), 0);
  endtask

  task automatic gen_random();
    int tries;
    tries = 0;
    do begin
      for (int ch = 0; ch < N; ch++) begin
        c_en[ch]    = ($urandom_range(0, 3) != 0) ? 1 : 0;
        c_pl[ch]    = $urandom_range(0, 3);
        c_size[ch]  = $urandom_range(0, 3);
        c_burst[ch] = $urandom_range(0, 3);
        c_left[ch]  = $urandom_range(0, 63);
        c_ndt[ch]   = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 40) : $urandom_range(0, 262143);
        c_req[ch]   = $urandom_range(0, 1);
        c_rel[ch]   = $urandom_range(0, 1);
      end
      tries++;
      if (tries > 50) set_stream(0, 0);
    end while (!any_elig());
  endtask

  initial begin
    clear_cfg();
    do_reset();

    // Single stream, word inc4 with exactly 16 bytes available.
    c_en[2] = 1; c_pl[2] = 1; c_size[2] = 2; c_burst[2] = 1;
    c_left[2] = 16; c_ndt[2] = 100; c_req[2] = 1; c_rel[2] = 1;
    start_scenario();
    repeat (2) next_burst(0);
    next_burst(2);
    do_reset();

    set_stream(1, 3);
    set_stream(5, 1);
    start_scenario();
    repeat (4) next_burst(0);
    do_reset();

    set_stream(0, 2);
    set_stream(3, 2);
    set_stream(6, 2);
    start_scenario();
    repeat (5) next_burst(0);
    do_reset();

    set_stream(4, 0);
    set_stream(7, 3);
    start_scenario();
    repeat (5) next_burst(0);
    do_reset();

    // hword inc8 needs 16 bytes: 15 left and 40 bytes pending blocks it, 14 pending does not.
    set_stream(0, 0);
    c_size[0] = 0;
    c_en[3] = 1; c_pl[3] = 3; c_size[3] = 1; c_burst[3] = 2;
    c_left[3] = 15; c_ndt[3] = 20; c_req[3] = 1; c_rel[3] = 1;
    start_scenario();
    @(posedge clk); #1;
    c_ndt[3] = 7;
    drive_cfg();
    next_burst(0);
    // Lock: disable the granted stream and raise another to top priority mid-burst.
    @(posedge clk); #1;
    c_en[3] = 0;
    set_stream(6, 3);
    drive_cfg();
    next_burst(0);
    do_reset();

    gen_random();
    start_scenario();
    repeat (60) begin
      @(posedge clk); #1;
      gen_random();
      drive_cfg();
      next_burst(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    do_reset();

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
